// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port. The winning writeback is latched into
// a one-entry output stage that drives the register file and doubles as an operand-forwarding source.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      hold_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      rf_write_o,
    output logic [ADDR_W-1:0]         rf_addr_o,
    output logic [DATA_W-1:0]         rf_data_o,
    output logic [IdW-1:0]            grant_id_o,
    output logic                      fwd_valid_o
);

    function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] idx);
        return (idx == IdW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [IdW-1:0]    ptr_q, ptr_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [IdW-1:0]    grant_id_q, grant_id_d;

    logic              win_found;
    logic [IdW-1:0]    win_idx;
    logic [IdW-1:0]    scan_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              transfer;

    // Scan from the round-robin pointer upwards, wrapping; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IdW'(i)) begin
                win_addr = req_addr_i[i*ADDR_W +: ADDR_W];
                win_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset dominates hold; neither allows a grant.
    assign transfer    = win_found && !hold_i && !reset;
    assign req_ready_o = transfer ? (NUM_REQ'(1) << win_idx) : '0;

    always_comb begin
        ptr_d      = ptr_q;
        rf_write_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        grant_id_d = grant_id_q;
        if (transfer) begin
            ptr_d      = wrap_inc(win_idx);
            // Writes to register 0 are consumed but never reach the register file.
            rf_write_d = |win_addr;
            rf_addr_d  = win_addr;
            rf_data_d  = win_data;
            grant_id_d = win_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q      <= '0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign rf_write_o  = rf_write_q;
    assign fwd_valid_o = rf_write_q;
    assign rf_addr_o   = rf_addr_q;
    assign rf_data_o   = rf_data_q;
    assign grant_id_o  = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a per-cycle vector table followed by a hand-written
// reset-after-grant sequence.
module tb_regfile_write_arbiter;

    localparam int unsigned NumReq = 3;
    localparam int unsigned AddrW  = 5;
    localparam int unsigned DataW  = 32;

    logic                     clock;
    logic                     reset;
    logic                     hold_i;
    logic [NumReq-1:0]        req_valid_i;
    logic [NumReq*AddrW-1:0]  req_addr_i;
    logic [NumReq*DataW-1:0]  req_data_i;
    logic [NumReq-1:0]        req_ready_o;
    logic                     rf_write_o;
    logic [AddrW-1:0]         rf_addr_o;
    logic [DataW-1:0]         rf_data_o;
    logic [1:0]               grant_id_o;
    logic                     fwd_valid_o;

    regfile_write_arbiter #(
        .NUM_REQ(NumReq),
        .ADDR_W (AddrW),
        .DATA_W (DataW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .hold_i     (hold_i),
        .req_valid_i(req_valid_i),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .req_ready_o(req_ready_o),
        .rf_write_o (rf_write_o),
        .rf_addr_o  (rf_addr_o),
        .rf_data_o  (rf_data_o),
        .grant_id_o (grant_id_o),
        .fwd_valid_o(fwd_valid_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        hold;
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_write;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_gid;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    // Default requester payloads: req2 -> r3, req1 -> r7, req0 -> r1.
    localparam logic [14:0] DefAddr = {5'd3, 5'd7, 5'd1};
    localparam logic [95:0] DefData = {32'hCCCC_0002, 32'hDEAD_BEEF, 32'hAAAA_0000};

    task automatic add(input logic rst, input logic hold, input logic [2:0] valid,
                       input logic [14:0] addr, input logic [95:0] data,
                       input logic [2:0] er, input logic ew, input logic [4:0] ea,
                       input logic [31:0] ed, input logic [1:0] eg);
        vec_t v;
        v.rst = rst; v.hold = hold; v.valid = valid; v.addr = addr; v.data = data;
        v.exp_ready = er; v.exp_write = ew; v.exp_addr = ea; v.exp_data = ed; v.exp_gid = eg;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check ready mid-cycle, check output stage after the next edge.
    task automatic run_vec(input vec_t v, input string tag);
        reset       = v.rst;
        hold_i      = v.hold;
        req_valid_i = v.valid;
        req_addr_i  = v.addr;
        req_data_i  = v.data;
        #3;
        check({tag, ".ready"}, 32'(req_ready_o), 32'(v.exp_ready));
        @(posedge clock);
        #1;
        check({tag, ".write"}, 32'(rf_write_o), 32'(v.exp_write));
        check({tag, ".fwd"},   32'(fwd_valid_o), 32'(v.exp_write));
        check({tag, ".addr"},  32'(rf_addr_o), 32'(v.exp_addr));
        check({tag, ".data"},  rf_data_o, v.exp_data);
        check({tag, ".gid"},   32'(grant_id_o), 32'(v.exp_gid));
    endtask

    initial begin
        vec_t v;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        hold_i      = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;

        //   rst hold valid  addr     data     ready  wr addr data            gid
        add(1, 0, 3'b111, DefAddr, DefData, 3'b000, 0, 5'd0, 32'h0,          2'd0);
        add(1, 0, 3'b111, DefAddr, DefData, 3'b000, 0, 5'd0, 32'h0,          2'd0);
        add(0, 0, 3'b111, DefAddr, DefData, 3'b001, 1, 5'd1, 32'hAAAA_0000,  2'd0);
        add(0, 0, 3'b010, DefAddr, DefData, 3'b010, 1, 5'd7, 32'hDEAD_BEEF,  2'd1);
        // ptr=2 here; then continuous round robin from ptr=0
        add(0, 0, 3'b111, DefAddr, DefData, 3'b100, 1, 5'd3, 32'hCCCC_0002,  2'd2);
        add(0, 0, 3'b111, DefAddr, DefData, 3'b001, 1, 5'd1, 32'hAAAA_0000,  2'd0);
        add(0, 0, 3'b111, DefAddr, DefData, 3'b010, 1, 5'd7, 32'hDEAD_BEEF,  2'd1);
        add(0, 0, 3'b111, DefAddr, DefData, 3'b100, 1, 5'd3, 32'hCCCC_0002,  2'd2);
        add(0, 0, 3'b111, DefAddr, DefData, 3'b001, 1, 5'd1, 32'hAAAA_0000,  2'd0);
        add(0, 0, 3'b111, DefAddr, DefData, 3'b010, 1, 5'd7, 32'hDEAD_BEEF,  2'd1);
        add(0, 0, 3'b111, DefAddr, DefData, 3'b100, 1, 5'd3, 32'hCCCC_0002,  2'd2);
        // address 0: consumed, no write, pointer advances to 1
        add(0, 0, 3'b001, {5'd3, 5'd7, 5'd0}, {64'h0, 32'h0000_1234},
            3'b001, 0, 5'd0, 32'h0000_1234, 2'd0);
        add(0, 0, 3'b011, DefAddr, DefData, 3'b010, 1, 5'd7, 32'hDEAD_BEEF,  2'd1);
        // hold for three cycles with req2 pending, then release
        add(0, 1, 3'b100, DefAddr, DefData, 3'b000, 0, 5'd7, 32'hDEAD_BEEF,  2'd1);
        add(0, 1, 3'b100, DefAddr, DefData, 3'b000, 0, 5'd7, 32'hDEAD_BEEF,  2'd1);
        add(0, 1, 3'b100, DefAddr, DefData, 3'b000, 0, 5'd7, 32'hDEAD_BEEF,  2'd1);
        add(0, 0, 3'b100, DefAddr, DefData, 3'b100, 1, 5'd3, 32'hCCCC_0002,  2'd2);
        add(0, 0, 3'b000, DefAddr, DefData, 3'b000, 0, 5'd3, 32'hCCCC_0002,  2'd2);
        // reset and hold together: reset wins
        add(1, 1, 3'b111, DefAddr, DefData, 3'b000, 0, 5'd0, 32'h0,          2'd0);
        add(0, 0, 3'b110, DefAddr, DefData, 3'b010, 1, 5'd7, 32'hDEAD_BEEF,  2'd1);
        add(0, 0, 3'b011, DefAddr, DefData, 3'b001, 1, 5'd1, 32'hAAAA_0000,  2'd0);

        @(posedge clock);
        #1;
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset in the cycle after a grant drops the pending write and rewinds the pointer.
        v = vecs[0];
        v.rst = 0; v.hold = 0; v.valid = 3'b100; v.exp_ready = 3'b100;
        v.exp_write = 1; v.exp_addr = 5'd3; v.exp_data = 32'hCCCC_0002; v.exp_gid = 2'd2;
        run_vec(v, "rst_after_grant.grant");
        v.rst = 1; v.valid = 3'b111; v.exp_ready = 3'b000;
        v.exp_write = 0; v.exp_addr = 5'd0; v.exp_data = 32'h0; v.exp_gid = 2'd0;
        run_vec(v, "rst_after_grant.reset");
        v.rst = 0; v.valid = 3'b111; v.exp_ready = 3'b001;
        v.exp_write = 1; v.exp_addr = 5'd1; v.exp_data = 32'hAAAA_0000; v.exp_gid = 2'd0;
        run_vec(v, "rst_after_grant.ptr0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
